// File: rtl/sha2_w_expander_stream.sv
// SHA-2 message-schedule expander: loads one 16-word block, then streams W0..W(ROUNDS-1),
// STEPS words per beat, over a valid/ready output handshake.
module sha2_w_expander_stream #(
    parameter int WORD   = 32,
    parameter int ROUNDS = 64,
    parameter int STEPS  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*WORD-1:0]     block_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STEPS*WORD-1:0]  w_out,
    output logic [6:0]             t_out,
    output logic                   last,
    output logic                   o_dbg_state
);

    localparam int BEATS = ROUNDS / STEPS;

    if (WORD != 32 && WORD != 64) begin : g_bad_word
        $error("sha2_w_expander_stream: WORD must be 32 or 64");
    end
    if (STEPS != 1 && STEPS != 2 && STEPS != 4 && STEPS != 8) begin : g_bad_steps
        $error("sha2_w_expander_stream: STEPS must be 1, 2, 4 or 8");
    end
    if (ROUNDS <= 16 || ROUNDS > 127 || (ROUNDS % STEPS) != 0) begin : g_bad_rounds
        $error("sha2_w_expander_stream: ROUNDS must be in 17..127 and divisible by STEPS");
    end

    // Rotate/shift amounts of the two small sigma functions for the chosen word width.
    localparam int S0_R1 = (WORD == 32) ? 7  : 1;
    localparam int S0_R2 = (WORD == 32) ? 18 : 8;
    localparam int S0_SH = (WORD == 32) ? 3  : 7;
    localparam int S1_R1 = (WORD == 32) ? 17 : 19;
    localparam int S1_R2 = (WORD == 32) ? 19 : 61;
    localparam int S1_SH = (WORD == 32) ? 10 : 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [16*WORD-1:0]   r_window;
    logic [6:0]           r_cnt;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_advance;
    logic [16*WORD-1:0]   w_window_next;

    function automatic logic [WORD-1:0] f_rotr(input logic [WORD-1:0] x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] f_sig0(input logic [WORD-1:0] x);
        return f_rotr(x, S0_R1) ^ f_rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD-1:0] f_sig1(input logic [WORD-1:0] x);
        return f_rotr(x, S1_R1) ^ f_rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // e[0] is the oldest word of the window; new word j may consume new words j-2 and j-7.
    function automatic logic [16*WORD-1:0] f_advance(input logic [16*WORD-1:0] win);
        logic [WORD-1:0]    e [16+STEPS];
        logic [16*WORD-1:0] res;
        for (int i = 0; i < 16; i++) begin
            e[i] = win[(16-i)*WORD-1 -: WORD];
        end
        for (int j = 0; j < STEPS; j++) begin
            e[16+j] = f_sig1(e[14+j]) + e[9+j] + f_sig0(e[1+j]) + e[j];
        end
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[(16-i)*WORD-1 -: WORD] = e[STEPS+i];
        end
        return res;
    endfunction

    assign w_window_next = f_advance(r_window);
    assign w_last        = (r_state == RUN) && (r_cnt == 7'(BEATS - 1));

    // Input: block taken when in_valid & in_ready & !flush. Output: beat consumed when
    // out_valid & out_ready & !flush; while stalled every output stays stable.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                if (out_ready && !flush) begin
                    if (w_last) begin
                        w_next_state = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_window <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_window <= block_in;
                r_cnt    <= '0;
            end else if (w_advance) begin
                r_window <= w_window_next;
                r_cnt    <= r_cnt + 7'd1;
            end
        end
    end

    assign w_out       = (r_state == RUN) ? r_window[16*WORD-1 -: STEPS*WORD] : '0;
    assign t_out       = (r_state == RUN) ? 7'(32'(r_cnt) * STEPS) : 7'd0;
    assign last        = w_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sha2_w_expander_stream.sv
// Bench for sha2_w_expander_stream: four configurations checked every cycle against a
// plain-arithmetic schedule model, driven by directed block vectors.
module tb_sha2_w_expander_stream;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         iv    [4];
    logic         o_rdy [4];
    logic         fl    [4];
    logic [1023:0] blk  [4];
    logic         ir    [4];
    logic         ov    [4];
    logic         lst   [4];
    logic         st    [4];
    logic [6:0]   tt    [4];
    logic [31:0]  wo0;
    logic [127:0] wo1;
    logic [127:0] wo2;
    logic [63:0]  wo3;

    bit           active [4];
    int           beat   [4];
    logic [63:0]  sched  [4][80];
    int           acc_q  [$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;

    always #5 CLK = ~CLK;

    sha2_w_expander_stream #(.WORD(32), .ROUNDS(64), .STEPS(1)) dut0 (
        .CLK(CLK), .RST(RST), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .block_in(blk[0][511:0]), .out_valid(ov[0]), .out_ready(o_rdy[0]), .w_out(wo0),
        .t_out(tt[0]), .last(lst[0]), .o_dbg_state(st[0]));
    sha2_w_expander_stream #(.WORD(64), .ROUNDS(80), .STEPS(2)) dut1 (
        .CLK(CLK), .RST(RST), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .block_in(blk[1]), .out_valid(ov[1]), .out_ready(o_rdy[1]), .w_out(wo1),
        .t_out(tt[1]), .last(lst[1]), .o_dbg_state(st[1]));
    sha2_w_expander_stream #(.WORD(32), .ROUNDS(64), .STEPS(4)) dut2 (
        .CLK(CLK), .RST(RST), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .block_in(blk[2][511:0]), .out_valid(ov[2]), .out_ready(o_rdy[2]), .w_out(wo2),
        .t_out(tt[2]), .last(lst[2]), .o_dbg_state(st[2]));
    sha2_w_expander_stream #(.WORD(32), .ROUNDS(64), .STEPS(2)) dut3 (
        .CLK(CLK), .RST(RST), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .block_in(blk[3][511:0]), .out_valid(ov[3]), .out_ready(o_rdy[3]), .w_out(wo3),
        .t_out(tt[3]), .last(lst[3]), .o_dbg_state(st[3]));

    function automatic int wword(input int id);
        return (id == 1) ? 64 : 32;
    endfunction

    function automatic int steps(input int id);
        case (id)
            0:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int rounds(input int id);
        return (id == 1) ? 80 : 64;
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & msk(w);
    endfunction

    function automatic logic [63:0] sg0(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
        return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sg1(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
        return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
    endfunction

    task automatic expand(input int id, input logic [1023:0] b);
        int w = wword(id);
        for (int t = 0; t < 16; t++) begin
            sched[id][t] = 64'(b >> ((15 - t) * w)) & msk(w);
        end
        for (int t = 16; t < rounds(id); t++) begin
            sched[id][t] = (sg1(sched[id][t-2], w) + sched[id][t-7]
                            + sg0(sched[id][t-15], w) + sched[id][t-16]) & msk(w);
        end
    endtask

    function automatic logic [511:0] exp_beat(input int id, input int b);
        logic [511:0] e = '0;
        for (int k = 0; k < steps(id); k++) begin
            e = (e << wword(id)) | 512'(sched[id][b * steps(id) + k]);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int id);
        logic [511:0] w;
        int           s = steps(id);
        int           nb = rounds(id) / steps(id);
        case (id)
            0:       w = 512'(wo0);
            1:       w = 512'(wo1);
            2:       w = 512'(wo2);
            default: w = 512'(wo3);
        endcase
        if (RST) begin
            chk("rst_out_valid", 512'(ov[id]), 512'(0));
            chk("rst_in_ready", 512'(ir[id]), 512'(1));
            chk("rst_last", 512'(lst[id]), 512'(0));
            chk("rst_t_out", 512'(tt[id]), 512'(0));
            chk("rst_w_out", w, 512'(0));
            active[id] = 1'b0;
            beat[id]   = 0;
            return;
        end
        chk("out_valid", 512'(ov[id]), 512'(active[id]));
        chk("in_ready", 512'(ir[id]), 512'(!active[id]));
        chk("dbg_state", 512'(st[id]), 512'(active[id]));
        if (active[id]) begin
            chk("w_out", w, exp_beat(id, beat[id]));
            chk("t_out", 512'(tt[id]), 512'(beat[id] * s));
            chk("last", 512'(lst[id]), 512'(beat[id] == nb - 1));
        end
        if (fl[id]) begin
            active[id] = 1'b0;
        end else if (active[id]) begin
            if (o_rdy[id]) begin
                if (beat[id] == nb - 1) active[id] = 1'b0;
                else beat[id] = beat[id] + 1;
            end
        end else if (iv[id]) begin
            expand(id, blk[id]);
            active[id] = 1'b1;
            beat[id]   = 0;
            if (id == 3) acc_q.push_back(cyc);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        for (int id = 0; id < 4; id++) check_inst(id);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1023:0] rnd_blk();
        logic [1023:0] b;
        for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic send(input int id, input logic [1023:0] b);
        int n = 0;
        blk[id] = b;
        iv[id]  = 1'b1;
        while (!(ir[id] && !fl[id]) && n < 200) begin
            tick();
            n++;
        end
        chk("send_timeout", 512'(n >= 200), 512'(0));
        tick();
        iv[id] = 1'b0;
    endtask

    task automatic drain(input int id, input bit rnd);
        int n = 0;
        while (active[id] && n < 3000) begin
            o_rdy[id] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        chk("drain_timeout", 512'(n >= 3000), 512'(0));
        o_rdy[id] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog @%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1023:0] b;
        int n;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; o_rdy[i] = 1'b1; fl[i] = 1'b0; blk[i] = '0;
            active[i] = 1'b0; beat[i] = 0;
        end
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // SHA-256 "abc", one word per beat
        b = '0;
        b[511 -: 32] = 32'h61626380;
        b[31:0]      = 32'h00000018;
        send(0, b);
        chk("abc256_first_t", 512'(tt[0]), 512'(0));
        chk("abc256_first_w", 512'(wo0), 512'(32'h61626380));
        drain(0, 1'b0);
        chk("model_w16_256", 512'(sched[0][16]), 512'(64'h61626380));
        chk("model_w17_256", 512'(sched[0][17]), 512'(64'h000F0000));

        // SHA-512 "abc", two words per beat
        b = '0;
        b[1023 -: 64] = 64'h6162638000000000;
        b[63:0]       = 64'h18;
        send(1, b);
        drain(1, 1'b0);
        chk("model_w16_512", 512'(sched[1][16]), 512'(64'h6162638000000000));
        chk("model_w17_512", 512'(sched[1][17]), 512'(64'h00030000000000C0));

        // four words per beat with random back-pressure
        send(2, rnd_blk());
        drain(2, 1'b1);
        send(2, rnd_blk());
        drain(2, 1'b1);

        // asynchronous reset mid-block, then a fresh block
        send(0, rnd_blk());
        o_rdy[0] = 1'b1;
        repeat (6) tick();
        #2 RST = 1'b1;
        #1;
        chk("async_rst_valid", 512'(ov[0]), 512'(0));
        chk("async_rst_ready", 512'(ir[0]), 512'(1));
        #4 RST = 1'b0;
        tick();
        send(0, rnd_blk());
        chk("post_rst_t", 512'(tt[0]), 512'(0));
        drain(0, 1'b0);

        // flush at beat 10 with in_valid held in the same cycle
        send(0, rnd_blk());
        o_rdy[0] = 1'b1;
        n = 0;
        while (beat[0] != 10 && n < 100) begin
            tick();
            n++;
        end
        chk("flush_reach_timeout", 512'(n >= 100), 512'(0));
        fl[0]  = 1'b1;
        iv[0]  = 1'b1;
        blk[0] = rnd_blk();
        tick();
        fl[0] = 1'b0;
        chk("flush_valid", 512'(ov[0]), 512'(0));
        chk("flush_ready", 512'(ir[0]), 512'(1));
        tick();
        iv[0] = 1'b0;
        chk("flush_restart_valid", 512'(ov[0]), 512'(1));
        chk("flush_restart_t", 512'(tt[0]), 512'(0));
        drain(0, 1'b0);

        // back-to-back blocks with in_valid held, two words per beat
        acc_q.delete();
        o_rdy[3] = 1'b1;
        iv[3]    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            blk[3] = rnd_blk();
            tick();
        end
        iv[3] = 1'b0;
        drain(3, 1'b0);
        chk("b2b_count", 512'(acc_q.size() >= 3), 512'(1));
        if (acc_q.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                chk("b2b_gap", 512'(acc_q[i] - acc_q[i-1]), 512'(33));
            end
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
